// File: rtl/adc_capture_pkg.sv
// Shared types and register map for the ADC capture engine.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_e;

  typedef enum logic [1:0] {
    TSRC_SW   = 2'd0,
    TSRC_RISE = 2'd1,
    TSRC_FALL = 2'd2,
    TSRC_RSVD = 2'd3
  } trig_src_e;

  localparam logic [19:0] REG_CTRL     = 20'h00000;
  localparam logic [19:0] REG_TRIG_SRC = 20'h00004;
  localparam logic [19:0] REG_DELAY    = 20'h00008;
  localparam logic [19:0] REG_TRIG_PTR = 20'h0000C;
  localparam logic [19:0] REG_WP       = 20'h00010;
  localparam logic [19:0] REG_DECIM    = 20'h00014;
  localparam logic [19:0] REG_SW_TRIG  = 20'h00018;
  localparam logic [19:0] BUF_BASE     = 20'h10000;

endpackage

// File: rtl/red_pitaya_adc_capture_if.sv
// Sys bus responder slot: one-cycle read/write strobes, single-cycle ack.
interface red_pitaya_adc_capture_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read (1-cycle latency).
module adc_capture_ram #(
  parameter int DW = 14,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/red_pitaya_adc_capture.sv
// Triggered ADC capture into a circular buffer with pre/post-trigger window, read back over sys bus.
// Define ADC_CAPTURE_DECIM_EN to add the DECIM register (write one sample every DECIM+1 cycles).
module red_pitaya_adc_capture
  import adc_capture_pkg::*;
#(
  parameter int ADC_DW = 14,
  parameter int RSZ    = 12
) (
  input  logic              adc_clk_i,
  input  logic              adc_rstn_i,
  input  logic [ADC_DW-1:0] adc_dat_i,
  input  logic              trig_i,
  output logic              trig_out_o,
  red_pitaya_adc_capture_if.slave sys
);

  cap_state_e       state_q, state_d;
  logic [RSZ-1:0]   wp_q, wp_d;
  logic [RSZ-1:0]   trig_ptr_q, trig_ptr_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [1:0]       trig_src_q;
  logic [31:0]      delay_q;
  logic             trig_q, trig_prev_q;
  logic             ram_we, accept, qualify;
  logic [ADC_DW-1:0] ram_rdata;

  logic [19:0] addr;
  logic        arm, abort, sw_trig, hw_trig, trig_hit, buf_hit, buf_rd_q;
  logic [31:0] reg_rdata, rdata_q;
  logic        ack_q;
  logic        unused_bits;

  assign addr        = sys.sys_addr[19:0];
  assign unused_bits = ^{sys.sys_sel, sys.sys_addr[31:20]};

  assign abort   = sys.sys_wen && (addr == REG_CTRL) && sys.sys_wdata[1];
  assign arm     = sys.sys_wen && (addr == REG_CTRL) && sys.sys_wdata[0] && !sys.sys_wdata[1];
  assign sw_trig = sys.sys_wen && (addr == REG_SW_TRIG);
  assign buf_hit = (addr[19:16] == BUF_BASE[19:16]) && ((addr[15:0] >> (RSZ + 2)) == 16'd0);

  always_comb begin
    case (trig_src_q)
      TSRC_RISE: hw_trig = trig_q && !trig_prev_q;
      TSRC_FALL: hw_trig = !trig_q && trig_prev_q;
      default:   hw_trig = 1'b0;
    endcase
  end

  // arm/abort in the same cycle take precedence over any trigger
  assign trig_hit = (sw_trig || hw_trig) && !(arm || abort);

`ifdef ADC_CAPTURE_DECIM_EN
  logic [16:0] decim_q, dcnt_q;

  assign qualify = (dcnt_q == 17'd0);

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      dcnt_q <= '0;
    end else if (arm) begin
      dcnt_q <= '0;
    end else if (state_q == ARMED || state_q == POST) begin
      dcnt_q <= qualify ? decim_q : dcnt_q - 17'd1;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i)                              decim_q <= '0;
    else if (sys.sys_wen && addr == REG_DECIM)    decim_q <= sys.sys_wdata[16:0];
  end
`else
  assign qualify = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    ram_we     = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ARMED: begin
        if (qualify) begin
          ram_we = 1'b1;
          wp_d   = wp_q + 1'b1;
        end
        if (trig_hit) begin
          accept  = 1'b1;
          state_d = POST;
          cnt_d   = delay_q;
          if (qualify) trig_ptr_d = wp_q;
          else         pend_d     = 1'b1;
        end
      end
      POST: begin
        // a trigger between qualified samples is pinned to the next written sample
        if (pend_q) begin
          if (qualify) begin
            ram_we     = 1'b1;
            wp_d       = wp_q + 1'b1;
            trig_ptr_d = wp_q;
            pend_d     = 1'b0;
          end
        end else if (cnt_q == 32'd0) begin
          state_d = DONE;
        end else if (qualify) begin
          ram_we = 1'b1;
          wp_d   = wp_q + 1'b1;
          cnt_d  = cnt_q - 32'd1;
        end
      end
      default: ;
    endcase
    if (abort) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else if (arm) begin
      state_d = ARMED;
      wp_d    = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      trig_ptr_q  <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      trig_out_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      trig_ptr_q  <= trig_ptr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      trig_q      <= trig_i;
      trig_prev_q <= trig_q;
      trig_out_o  <= accept;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      trig_src_q <= '0;
      delay_q    <= '0;
    end else if (sys.sys_wen) begin
      if (addr == REG_TRIG_SRC) trig_src_q <= sys.sys_wdata[1:0];
      if (addr == REG_DELAY)    delay_q    <= sys.sys_wdata;
    end
  end

  adc_capture_ram #(.DW(ADC_DW), .AW(RSZ)) u_ram (
    .clk   (adc_clk_i),
    .we    (ram_we),
    .waddr (wp_q),
    .wdata (adc_dat_i),
    .raddr (addr[RSZ+1:2]),
    .rdata (ram_rdata)
  );

  always_comb begin
    reg_rdata = '0;
    case (addr)
      REG_CTRL:     reg_rdata = {29'd0, state_q == DONE,
                                 (state_q == POST) || (state_q == DONE),
                                 (state_q == ARMED) || (state_q == POST)};
      REG_TRIG_SRC: reg_rdata = {30'd0, trig_src_q};
      REG_DELAY:    reg_rdata = delay_q;
      REG_TRIG_PTR: reg_rdata = 32'(trig_ptr_q);
      REG_WP:       reg_rdata = 32'(wp_q);
`ifdef ADC_CAPTURE_DECIM_EN
      REG_DECIM:    reg_rdata = 32'(decim_q);
`endif
      default:      reg_rdata = '0;
    endcase
  end

  // buffer reads take one extra cycle for the registered RAM output
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      buf_rd_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      buf_rd_q <= sys.sys_ren && buf_hit;
      ack_q    <= 1'b0;
      if (buf_rd_q) begin
        ack_q   <= 1'b1;
        rdata_q <= {{(32-ADC_DW){ram_rdata[ADC_DW-1]}}, ram_rdata};
      end else if (sys.sys_ren && !buf_hit) begin
        ack_q   <= 1'b1;
        rdata_q <= reg_rdata;
      end else if (sys.sys_wen) begin
        ack_q   <= 1'b1;
      end
    end
  end

  assign sys.sys_ack   = ack_q;
  assign sys.sys_rdata = rdata_q;
  assign sys.sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_adc_capture.sv
// Bench for red_pitaya_adc_capture (RSZ=4 so wrap-around is reachable); read results go through a scoreboard queue.
module tb_red_pitaya_adc_capture;

  localparam int RSZ = 4;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_TSRC  = 32'h04;
  localparam logic [31:0] A_DELAY = 32'h08;
  localparam logic [31:0] A_TPTR  = 32'h0C;
  localparam logic [31:0] A_WP    = 32'h10;
  localparam logic [31:0] A_DECIM = 32'h14;
  localparam logic [31:0] A_SWTRG = 32'h18;
  localparam logic [31:0] A_BUF   = 32'h10000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] adc_dat;
  logic        trig;
  logic        trig_out;

  red_pitaya_adc_capture_if bus ();

  red_pitaya_adc_capture #(.ADC_DW(14), .RSZ(RSZ)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rstn),
    .adc_dat_i  (adc_dat),
    .trig_i     (trig),
    .trig_out_o (trig_out),
    .sys        (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          ramp_en = 1'b0;
  logic [13:0] fixed_val = 14'h3E0C;
  int          ca;

  string       q_tag[$];
  logic [31:0] q_exp[$];

  // ADC source changes on the falling edge; sample written at posedge k after arm is ca+1+k
  initial begin
    adc_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      adc_dat = ramp_en ? 14'(cyc) : fixed_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int v);
    logic [13:0] s;
    s = 14'(v);
    return {{18{s[13]}}, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    tick();
    bus.sys_wen = 1'b0;
    chk("wr_ack", 32'(bus.sys_ack), 32'd1);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag, input int exp_lat);
    int          lat;
    string       t;
    logic [31:0] e;
    q_exp.push_back(exp);
    q_tag.push_back(tag);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    tick();
    bus.sys_ren = 1'b0;
    lat = 1;
    while (!bus.sys_ack && lat < 6) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    t = q_tag.pop_front();
    e = q_exp.pop_front();
    if (bus.sys_ack) chk(t, bus.sys_rdata, e);
  endtask

  task automatic rd_buf(input int n, input logic [31:0] exp, input string tag);
    bus_rd(A_BUF + 32'(4 * n), exp, tag, 2);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    trig = 1'b0;
    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_sel   = 4'hF;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;
    repeat (3) tick();
    chk("rst_trig_out", 32'(trig_out), 32'd0);
    chk("rst_ack", 32'(bus.sys_ack), 32'd0);
    chk("rst_rdata", bus.sys_rdata, 32'd0);
    rstn = 1'b1;
    tick();
    bus_rd(A_CTRL, 32'd0, "rst_ctrl", 1);
    bus_rd(A_WP, 32'd0, "rst_wp", 1);
    bus_rd(A_TPTR, 32'd0, "rst_tptr", 1);
    bus_rd(A_DELAY, 32'd0, "rst_delay", 1);

    // prefill whole buffer with -500, abort while ARMED
    bus_wr(A_CTRL, 32'd1);
    repeat (20) tick();
    bus_wr(A_CTRL, 32'd2);
    bus_rd(A_CTRL, 32'd0, "pre_ctrl", 1);
    bus_rd(A_WP, 32'd5, "pre_wp", 1);
    rd_buf(5, 32'hFFFFFE0C, "neg_sample");
    bus_rd(32'h20, 32'd0, "unmapped", 1);
    bus_rd(A_BUF + 32'(4 * (2**RSZ)), 32'd0, "buf_oob", 1);
`ifndef ADC_CAPTURE_DECIM_EN
    bus_wr(A_DECIM, 32'd5);
    bus_rd(A_DECIM, 32'd0, "decim_absent", 1);
`endif

    // software trigger at wp=10, DELAY=3
    ramp_en = 1'b1;
    bus_wr(A_TSRC, 32'd0);
    bus_wr(A_DELAY, 32'd3);
    bus_rd(A_DELAY, 32'd3, "delay_rb", 1);
    bus_wr(A_CTRL, 32'd1);
    ca = cyc;
    repeat (10) tick();
    bus_wr(A_SWTRG, 32'd1);
    chk("t1_trig_out_hi", 32'(trig_out), 32'd1);
    tick();
    chk("t1_trig_out_lo", 32'(trig_out), 32'd0);
    repeat (5) tick();
    bus_rd(A_CTRL, 32'h6, "t1_ctrl", 1);
    bus_rd(A_TPTR, 32'd10, "t1_tptr", 1);
    bus_rd(A_WP, 32'd14, "t1_wp", 1);
    for (int n = 10; n < 14; n++) rd_buf(n, sx(ca + 1 + n), "t1_buf");
    rd_buf(14, 32'hFFFFFE0C, "t1_unwritten");

    // rising edge on trig_i, DELAY=0
    bus_wr(A_TSRC, 32'd1);
    bus_wr(A_DELAY, 32'd0);
    bus_wr(A_CTRL, 32'd1);
    ca = cyc;
    repeat (50) tick();
    trig = 1'b1;
    tick();
    chk("t2_trig_out_pre", 32'(trig_out), 32'd0);
    tick();
    chk("t2_trig_out_hi", 32'(trig_out), 32'd1);
    tick();
    chk("t2_trig_out_lo", 32'(trig_out), 32'd0);
    bus_rd(A_CTRL, 32'h6, "t2_ctrl", 1);
    bus_rd(A_TPTR, 32'd3, "t2_tptr", 1);
    bus_rd(A_WP, 32'd4, "t2_wp", 1);
    rd_buf(3, sx(ca + 52), "t2_trig_sample");
    rd_buf(4, sx(ca + 37), "t2_old_sample");

    // falling edge on trig_i, DELAY=1
    bus_wr(A_TSRC, 32'd2);
    bus_wr(A_DELAY, 32'd1);
    bus_wr(A_CTRL, 32'd1);
    repeat (5) tick();
    trig = 1'b0;
    tick();
    chk("t3_trig_out_pre", 32'(trig_out), 32'd0);
    tick();
    chk("t3_trig_out_hi", 32'(trig_out), 32'd1);
    repeat (3) tick();
    bus_rd(A_TPTR, 32'd6, "t3_tptr", 1);
    bus_rd(A_WP, 32'd8, "t3_wp", 1);
    bus_rd(A_CTRL, 32'h6, "t3_ctrl", 1);

    // wrap: trigger at wp=3, DELAY=20
    bus_wr(A_TSRC, 32'd0);
    bus_wr(A_DELAY, 32'd20);
    bus_wr(A_CTRL, 32'd1);
    ca = cyc;
    repeat (3) tick();
    bus_wr(A_SWTRG, 32'd0);
    repeat (25) tick();
    bus_rd(A_WP, 32'd8, "wrap_wp", 1);
    bus_rd(A_TPTR, 32'd3, "wrap_tptr", 1);
    bus_rd(A_CTRL, 32'h6, "wrap_ctrl", 1);
    for (int i = 0; i < 16; i++) rd_buf(i, sx(ca + 1 + ((i >= 8) ? i : i + 16)), "wrap_buf");

    // arm+abort together: abort wins, pointers untouched
    bus_wr(A_CTRL, 32'd3);
    bus_rd(A_CTRL, 32'd0, "armabort_ctrl", 1);
    bus_rd(A_WP, 32'd8, "armabort_wp", 1);

    // abort during POST
    bus_wr(A_DELAY, 32'd100);
    bus_wr(A_CTRL, 32'd1);
    repeat (2) tick();
    bus_wr(A_SWTRG, 32'd1);
    bus_rd(A_CTRL, 32'h3, "post_ctrl", 1);
    repeat (4) tick();
    bus_wr(A_CTRL, 32'd2);
    repeat (5) tick();
    bus_rd(A_CTRL, 32'd0, "abort_ctrl", 1);
    bus_rd(A_WP, 32'd9, "abort_wp", 1);
    bus_wr(A_SWTRG, 32'd1);
    chk("idle_trig_ignored", 32'(trig_out), 32'd0);
    bus_rd(A_CTRL, 32'd0, "idle_ctrl", 1);

`ifdef ADC_CAPTURE_DECIM_EN
    bus_wr(A_DECIM, 32'd3);
    bus_rd(A_DECIM, 32'd3, "decim_rb", 1);
    bus_wr(A_DELAY, 32'd2);
    bus_wr(A_CTRL, 32'd1);
    ca = cyc;
    repeat (2) tick();
    bus_wr(A_SWTRG, 32'd1);
    chk("decim_trig_out", 32'(trig_out), 32'd1);
    repeat (12) tick();
    bus_rd(A_CTRL, 32'h6, "decim_ctrl", 1);
    bus_rd(A_TPTR, 32'd1, "decim_tptr", 1);
    bus_rd(A_WP, 32'd4, "decim_wp", 1);
    for (int j = 0; j < 4; j++) rd_buf(j, sx(ca + 1 + 4 * j), "decim_buf");
`endif

    // reset mid-capture
    bus_wr(A_TSRC, 32'd1);
    bus_wr(A_CTRL, 32'd1);
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    bus_rd(A_WP, 32'd0, "rst_mid_wp", 1);
    bus_rd(A_CTRL, 32'd0, "rst_mid_ctrl", 1);
    bus_rd(A_TSRC, 32'd0, "rst_mid_tsrc", 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
